// File: rtl/alu_nbit_seq_if.sv
// Request/response bundle for alu_nbit_seq.
// The zero/neg/ovf flag signals exist only when ALU_NBIT_SEQ_FLAGS_EN is defined.
interface alu_nbit_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] OP1;
  logic [WIDTH-1:0] OP2;
  logic             cin;
  logic [2:0]       opsel;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef ALU_NBIT_SEQ_FLAGS_EN
  logic             zero;
  logic             neg;
  logic             ovf;
`endif

  modport master (
    output in_valid, OP1, OP2, cin, opsel, mode, out_ready,
    input  in_ready, out_valid, result, cout
`ifdef ALU_NBIT_SEQ_FLAGS_EN
    , input zero, neg, ovf
`endif
  );

  modport slave (
    input  in_valid, OP1, OP2, cin, opsel, mode, out_ready,
    output in_ready, out_valid, result, cout
`ifdef ALU_NBIT_SEQ_FLAGS_EN
    , output zero, neg, ovf
`endif
  );
endinterface

// File: rtl/alu_nbit_seq.sv
// Slice-serial ALU: one SLICE-bit chunk per cycle, result after exactly NSLICE busy cycles.
// Optional zero/neg/ovf flags are built when ALU_NBIT_SEQ_FLAGS_EN is defined.
module alu_nbit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_nbit_seq_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic             cin_q, cin_d, mode_q, mode_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [2:0]       opsel_q, opsel_d;
`ifdef ALU_NBIT_SEQ_FLAGS_EN
  logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic             ovf_fin;
`endif

  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE-1:0] l_sl [NSLICE];
  logic [WIDTH-1:0] logic_w;
  logic [SLICE-1:0] a_s, b_s, bb, slice_res;
  logic [SLICE:0]   sum;
  logic             c0, cy_in, arith_en, cout_fin;

  // Logic-mode word is pure wiring; it is then consumed one slice at a time.
  always_comb begin
    logic_w = '0;
    case (opsel_q)
      3'b000:  logic_w = op1_q & op2_q;
      3'b001:  logic_w = op1_q | op2_q;
      3'b010:  logic_w = op1_q ^ op2_q;
      3'b011:  logic_w = ~op1_q;
      3'b100:  logic_w = {op1_q[WIDTH-2:0], cin_q};
      3'b101:  logic_w = {cin_q, op1_q[WIDTH-1:1]};
      default: logic_w = '0;
    endcase
  end

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign a_sl[gi] = op1_q[gi*SLICE +: SLICE];
    assign b_sl[gi] = op2_q[gi*SLICE +: SLICE];
    assign l_sl[gi] = logic_w[gi*SLICE +: SLICE];
    assign acc_d[gi*SLICE +: SLICE] = (state_q == BUSY && cnt_q == CW'(gi)) ?
                                      slice_res : acc_q[gi*SLICE +: SLICE];
  end

  assign a_s      = a_sl[cnt_q];
  assign b_s      = b_sl[cnt_q];
  assign arith_en = !mode_q && !opsel_q[2];

  always_comb begin
    bb = '0;
    c0 = 1'b0;
    case (opsel_q[1:0])
      2'b00:   begin bb = b_s;  c0 = cin_q; end
      2'b01:   begin bb = ~b_s; c0 = 1'b1;  end
      2'b10:   begin bb = '0;   c0 = 1'b1;  end
      default: begin bb = '1;   c0 = 1'b0;  end
    endcase
    cy_in = (cnt_q == '0) ? c0 : carry_q;
    sum   = {1'b0, a_s} + {1'b0, bb} + {{SLICE{1'b0}}, cy_in};
    if (mode_q)        slice_res = l_sl[cnt_q];
    else if (arith_en) slice_res = sum[SLICE-1:0];
    else               slice_res = '0;
    cout_fin = 1'b0;
    if (arith_en)                            cout_fin = sum[SLICE];
    else if (mode_q && opsel_q == 3'b100)    cout_fin = op1_q[WIDTH-1];
    else if (mode_q && opsel_q == 3'b101)    cout_fin = op1_q[0];
  end

`ifdef ALU_NBIT_SEQ_FLAGS_EN
  // Carry into the MSB is recovered from the top bit's sum; only meaningful on the last slice.
  assign ovf_fin = arith_en && (a_s[SLICE-1] ^ bb[SLICE-1] ^ sum[SLICE-1] ^ sum[SLICE]);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cin_d    = cin_q;
    opsel_d  = opsel_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ALU_NBIT_SEQ_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op1_d   = bus.OP1;
          op2_d   = bus.OP2;
          cin_d   = bus.cin;
          opsel_d = bus.opsel;
          mode_d  = bus.mode;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        carry_d = sum[SLICE];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = acc_d;
          cout_d   = cout_fin;
`ifdef ALU_NBIT_SEQ_FLAGS_EN
          zero_d   = (acc_d == '0);
          neg_d    = acc_d[WIDTH-1];
          ovf_d    = ovf_fin;
`endif
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      cin_q    <= 1'b0;
      opsel_q  <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ALU_NBIT_SEQ_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      cin_q    <= cin_d;
      opsel_q  <= opsel_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ALU_NBIT_SEQ_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
`ifdef ALU_NBIT_SEQ_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: doc/alu_nbit_seq.md
ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 8, meaning bits processed per cycle; WIDTH % SLICE == 0 and NSLICE = WIDTH/SLICE.
REQ-003 The block SHALL have port clk  input  1  the single clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  operation request.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-007 The block SHALL have ports OP1 and OP2  input  WIDTH  operands.
REQ-008 The block SHALL have port cin  input  1  carry/shift-in.
REQ-009 The block SHALL have ports opsel (input, 3, operation select) and mode (input, 1, 0=arithmetic, 1=logic).
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have ports result (output, WIDTH) and cout (output, 1, carry/shift-out).

Function
REQ-013 mode=0: opsel 000 OP1+OP2+cin; 001 OP1+~OP2+1, cin ignored; 010 OP1+1; 011 OP1+all-ones; 1xx result=0, cout=0.
REQ-014 Arithmetic cout SHALL be the carry out of bit WIDTH-1; for subtract, cout=1 means no borrow.
REQ-015 mode=1: opsel 000 AND; 001 OR; 010 XOR; 011 ~OP1; 100 SHL1, cin into bit 0, cout=OP1[WIDTH-1]; 101 SHR1, cin into bit WIDTH-1, cout=OP1[0]; 11x result=0, cout=0; bitwise ops give cout=0.
REQ-016 FSM states SHALL be IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-017 On in_valid&in_ready, OP1, OP2, cin, opsel and mode SHALL be registered, the slice counter cleared, and the FSM moved to BUSY.
REQ-018 In BUSY, each cycle SHALL compute slice count (bits count*SLICE .. count*SLICE+SLICE-1) and register its carry into the next slice; slice 0 uses the op's initial carry.
REQ-019 After NSLICE BUSY cycles the FSM SHALL enter DONE; out_valid SHALL rise exactly NSLICE cycles after the accepting edge, for every op.
REQ-020 In DONE, result and cout (and flags) SHALL be held stable until out_valid&out_ready, then the FSM SHALL return to IDLE on that edge.
REQ-021 Input changes after acceptance SHALL not affect the in-flight operation; in_valid in BUSY/DONE SHALL be ignored.
REQ-022 Outside DONE, out_valid=0; result/cout hold their last values.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, result=0, cout=0, flags=0, counter=0.
REQ-024 Reset asserted during BUSY or DONE SHALL abort the operation with no out_valid pulse.

Configuration
REQ-025 Macro ALU_NBIT_SEQ_FLAGS_EN SHALL, when defined, add outputs zero (result==0), neg (result[WIDTH-1]) and ovf (signed overflow, carry-into-MSB XOR carry-out, arithmetic only; 0 in logic mode), valid with out_valid.
REQ-026 Without ALU_NBIT_SEQ_FLAGS_EN, these ports and their logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=32, SLICE=8, flags enabled)
REQ-027 mode0/000, OP1=0xFFFFFFFF, OP2=1, cin=0 -> result 0x00000000, cout=1, zero=1, ovf=0, out_valid 4 cycles after accept.
REQ-028 mode0/001, OP1=5, OP2=7 -> result 0xFFFFFFFE, cout=0, neg=1; OP1=0x7FFFFFFF, OP2=0xFFFFFFFF (001) -> ovf=1.
REQ-029 mode1/100, OP1=0x80000001, cin=1 -> result 0x00000003, cout=1; mode1/101 same inputs -> 0xC0000000, cout=1.
REQ-030 Hold out_ready=0 for 10 cycles in DONE with changing inputs and in_valid=1 -> result stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-031 Assert rst_n=0 in 2nd BUSY cycle -> out_valid never pulses, result=0, in_ready=1 after release; next op completes correctly.
